// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART frame loader.
// Holds the default sync marker, the receiver and parser state encodings,
// and the pixel colour bit positions used by the panel driver.
package uart_frame_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic {
    P_HUNT,
    P_LOAD
  } parse_state_t;

  localparam int RED_BIT   = 0;
  localparam int BLUE_BIT  = 1;
  localparam int GREEN_BIT = 2;

  // Map a received byte to a panel pixel; the upper five bits carry no colour.
  function automatic logic [2:0] byte_to_pixel(input logic [7:0] b);
    logic [2:0] p;
    p            = '0;
    p[RED_BIT]   = b[RED_BIT];
    p[BLUE_BIT]  = b[BLUE_BIT];
    p[GREEN_BIT] = b[GREEN_BIT];
    return p;
  endfunction

endpackage

// File: rtl/uart_rx_8n1.sv
// 8N1 serial receiver with a two-flop input synchroniser.
// Ports:
//   clk        system clock
//   reset      synchronous active-low reset
//   uart_data  asynchronous serial line, idle high
//   byte_valid one-cycle strobe, rx_byte holds the received byte
//   rx_byte    received byte (valid with byte_valid)
//   frame_err  one-cycle strobe when the stop bit is sampled low
module uart_rx_8n1
  import uart_frame_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_data,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic             sync_p0, sync_p1;
  logic             line;
  rx_state_t        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shreg, shreg_n;
  // Armed means a high line has been seen since the last start, so a held-low
  // break cannot retrigger the receiver.
  logic             armed, armed_n;

  assign line    = sync_p1;
  assign rx_byte = shreg;

  always_comb begin
    state_n    = state;
    cnt_n      = cnt + 1'b1;
    bit_idx_n  = bit_idx;
    shreg_n    = shreg;
    armed_n    = armed;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    case (state)
      RX_IDLE: begin
        cnt_n = '0;
        if (line) begin
          armed_n = 1'b1;
        end else if (armed) begin
          state_n = RX_START;
          armed_n = 1'b0;
        end
      end
      RX_START: begin
        if (cnt == HALF_LAST) begin
          cnt_n = '0;
          if (line) begin
            state_n = RX_IDLE;
            armed_n = 1'b1;
          end else begin
            state_n   = RX_DATA;
            bit_idx_n = '0;
          end
        end
      end
      RX_DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n     = '0;
          shreg_n   = {line, shreg[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n   = '0;
          state_n = RX_IDLE;
          if (line) begin
            byte_valid = 1'b1;
            armed_n    = 1'b1;
          end else begin
            frame_err = 1'b1;
          end
        end
      end
      default: state_n = RX_IDLE;
    endcase
  end

  // Stage p0/p1: synchroniser, then receiver state
  always_ff @(posedge clk) begin
    shreg <= shreg_n;
    if (!reset) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      state   <= RX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      armed   <= 1'b0;
    end else begin
      sync_p0 <= uart_data;
      sync_p1 <= sync_p0;
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      armed   <= armed_n;
    end
  end

endmodule

// File: rtl/uart_frame_loader.sv
// Serial frame loader: hunts for a sync byte on uart_data and turns the
// following bytes into pixel writes for the LED panel frame buffer.
// Ports:
//   clk, reset   system clock, synchronous active-low reset
//   uart_data    asynchronous 8N1 serial input, idle high
//   wr_en        one-cycle pixel write strobe
//   wr_addr      pixel index 0..PIXELS-1 (held between writes)
//   wr_data      pixel colour {green, blue, red} (held between writes)
//   frame_done   pulses with the final pixel write of a frame
//   rx_error     sticky framing-error flag, cleared by reset only
//   busy         high while a frame is being loaded
module uart_frame_loader
  import uart_frame_pkg::*;
#(
  parameter int         CLOCK_RATE = 1000,
  parameter int         BAUD_RATE  = 125,
  parameter int         PIXELS     = 32,
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT,
  localparam int        ADDR_W     = (PIXELS > 1) ? $clog2(PIXELS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              uart_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [2:0]        wr_data,
  output logic              frame_done,
  output logic              rx_error,
  output logic              busy
);

  localparam int CLKS_PER_BIT = CLOCK_RATE / BAUD_RATE;
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(PIXELS - 1);

  generate
    if ((CLOCK_RATE % BAUD_RATE) != 0 || CLKS_PER_BIT < 4) begin : g_bad_baud
      $error("CLOCK_RATE/BAUD_RATE must be an integer of at least 4");
    end
  endgenerate

  logic         byte_valid, frame_err;
  logic [7:0]   rx_byte;

  parse_state_t      state, state_n;
  logic [ADDR_W-1:0] pix_cnt, pix_cnt_n;
  logic              wr_fire, last_fire, err_set;

  logic              vld_p0, done_p0, busy_p0, err_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [2:0]        data_p0;

  uart_rx_8n1 #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .uart_data (uart_data),
    .byte_valid(byte_valid),
    .rx_byte   (rx_byte),
    .frame_err (frame_err)
  );

  always_comb begin
    state_n   = state;
    pix_cnt_n = pix_cnt;
    wr_fire   = 1'b0;
    last_fire = 1'b0;
    err_set   = 1'b0;
    if (frame_err) begin
      err_set = 1'b1;
      state_n = P_HUNT;
    end else if (byte_valid) begin
      case (state)
        P_HUNT: begin
          if (rx_byte == SYNC_BYTE) begin
            state_n   = P_LOAD;
            pix_cnt_n = '0;
          end
        end
        P_LOAD: begin
          if (rx_byte == SYNC_BYTE) begin
            pix_cnt_n = '0;
          end else begin
            wr_fire = 1'b1;
            if (pix_cnt == LAST_PIX) begin
              last_fire = 1'b1;
              state_n   = P_HUNT;
              pix_cnt_n = '0;
            end else begin
              pix_cnt_n = pix_cnt + 1'b1;
            end
          end
        end
        default: state_n = P_HUNT;
      endcase
    end
  end

  // Stage p0: registered write port; busy lingers through the frame_done cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= P_HUNT;
      pix_cnt <= '0;
      vld_p0  <= 1'b0;
      done_p0 <= 1'b0;
      busy_p0 <= 1'b0;
      err_p0  <= 1'b0;
      addr_p0 <= '0;
      data_p0 <= '0;
    end else begin
      state   <= state_n;
      pix_cnt <= pix_cnt_n;
      vld_p0  <= wr_fire;
      done_p0 <= last_fire;
      busy_p0 <= (state_n == P_LOAD) || last_fire;
      if (err_set) err_p0 <= 1'b1;
      if (wr_fire) begin
        addr_p0 <= pix_cnt;
        data_p0 <= byte_to_pixel(rx_byte);
      end
    end
  end

  assign wr_en      = vld_p0;
  assign wr_addr    = addr_p0;
  assign wr_data    = data_p0;
  assign frame_done = done_p0;
  assign busy       = busy_p0;
  assign rx_error   = err_p0;

endmodule
